if_pc_unit: RTL and testbench

Parametrised program-counter unit for the instruction-fetch stage. It holds the PC and selects the next address from several sources: sequential increment, EX-stage branch redirect, ID-stage jump redirect, or a buffered pending redirect. It also supports stall, continuous or single-step run modes for the debug unit, and a terminal HALT state. It sits between the hazard/branch logic and the instruction-memory address port.

---
 rtl/if_pkg.sv | 18 +
 rtl/if_pc_redirect.sv | 53 +++++
 rtl/if_pc_unit.sv | 104 ++++++++++
 tb/tb_if_pc_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch PC unit.
// FSM encoding, default PC increment and target-alignment helper.
package if_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN       = 2'd0;
   localparam state_t ST_STEP_IDLE = 2'd1;
   localparam state_t ST_HALTED    = 2'd2;

   localparam int unsigned PC_STEP_DEF = 4;

   // Keeps the bits above log2(step); step is a power of two.
   function automatic logic [63:0] align_mask(input int unsigned step);
      return ~(64'(step) - 64'd1);
   endfunction

endpackage

// File: rtl/if_pc_redirect.sv
// Next-PC priority mux and the single pending-redirect entry.
// Redirects seen while the PC cannot advance are parked here.
module if_pc_redirect
   import if_pkg::*;
#(
   parameter int NB_ADDR = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_adv,
   input  logic               i_capture,
   input  logic               i_branch_taken,
   input  logic [NB_ADDR-1:0] i_branch_target,
   input  logic               i_jump,
   input  logic [NB_ADDR-1:0] i_jump_target,
   input  logic [NB_ADDR-1:0] i_mask,
   input  logic [NB_ADDR-1:0] i_pc_plus,
   output logic [NB_ADDR-1:0] o_next_pc
);

   logic               pend_valid;
   logic [NB_ADDR-1:0] pend_target;
   logic [NB_ADDR-1:0] redir_target;
   logic               sel_redir;
   logic               sel_pend;

   assign redir_target = (i_branch_taken ? i_branch_target
                                         : i_jump_target) & i_mask;

   always_comb begin
      sel_redir = i_branch_taken | i_jump;
      sel_pend  = !sel_redir & pend_valid;
      o_next_pc = i_pc_plus;
      unique case (1'b1)
         sel_redir: o_next_pc = redir_target;
         sel_pend:  o_next_pc = pend_target;
         default:   o_next_pc = i_pc_plus;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else if (i_adv) begin
         pend_valid  <= 1'b0;
      end else if (i_capture && sel_redir) begin
         pend_valid  <= 1'b1;
         pend_target <= redir_target;
      end
   end

endmodule

// File: rtl/if_pc_unit.sv
// Fetch-stage program counter: run/step/halt FSM, PC register,
// saturating fetch counter and sticky misaligned-target flag.
module if_pc_unit
   import if_pkg::*;
#(
   parameter int                 NB_ADDR      = 32,
   parameter logic [NB_ADDR-1:0] RESET_VECTOR = '0,
   parameter int unsigned        PC_STEP      = PC_STEP_DEF,
   parameter int                 NB_CNT       = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_mode,
   input  logic               i_step,
   input  logic               i_stall,
   input  logic               i_branch_taken,
   input  logic [NB_ADDR-1:0] i_branch_target,
   input  logic               i_jump,
   input  logic [NB_ADDR-1:0] i_jump_target,
   input  logic               i_halt,
   output logic [NB_ADDR-1:0] o_pc,
   output logic [NB_ADDR-1:0] o_pc_plus,
   output logic               o_valid,
   output logic               o_halted,
   output logic               o_addr_err,
   output logic [NB_CNT-1:0]  o_fetch_count
);

   localparam logic [NB_ADDR-1:0] MASK =
      NB_ADDR'(align_mask(PC_STEP));
   localparam logic [NB_ADDR-1:0] STEP = NB_ADDR'(PC_STEP);

   state_t             state;
   state_t             state_nx;
   logic               adv;
   logic               halt_acc;
   logic               capture;
   logic               err_set;
   logic [NB_ADDR-1:0] next_pc;

   assign o_pc_plus = o_pc + STEP;
   assign o_halted  = (state == ST_HALTED);

   assign adv = i_enable & !i_stall &
                ((state == ST_RUN) |
                 ((state == ST_STEP_IDLE) & i_step));
   assign o_valid  = adv;
   assign halt_acc = i_halt & adv & !i_branch_taken;
   assign capture  = !adv & !o_halted;

   // Flag only the target that would actually be taken.
   assign err_set = !o_halted &
      ((i_branch_taken & |(i_branch_target & ~MASK)) |
       (!i_branch_taken & i_jump & |(i_jump_target & ~MASK)));

   if_pc_redirect #(
      .NB_ADDR(NB_ADDR)
   ) u_redirect (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_adv          (adv),
      .i_capture      (capture),
      .i_branch_taken (i_branch_taken),
      .i_branch_target(i_branch_target),
      .i_jump         (i_jump),
      .i_jump_target  (i_jump_target),
      .i_mask         (MASK),
      .i_pc_plus      (o_pc_plus),
      .o_next_pc      (next_pc)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_RUN: begin
            if (halt_acc)    state_nx = ST_HALTED;
            else if (i_mode) state_nx = ST_STEP_IDLE;
         end
         ST_STEP_IDLE: begin
            if (halt_acc)     state_nx = ST_HALTED;
            else if (!i_mode) state_nx = ST_RUN;
         end
         ST_HALTED: state_nx = ST_HALTED;
         default:   state_nx = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state         <= ST_RUN;
         o_pc          <= RESET_VECTOR;
         o_addr_err    <= 1'b0;
         o_fetch_count <= '0;
      end else begin
         state <= state_nx;
         if (adv) o_pc <= next_pc;
         if (err_set) o_addr_err <= 1'b1;
         if (adv && !(&o_fetch_count))
            o_fetch_count <= o_fetch_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_if_pc_unit.sv
// Vector-table bench for if_pc_unit with a 32-bit and an 8-bit instance.
module tb_if_pc_unit;

   typedef struct packed {
      logic        en, mode, step, stall, br, jp, halt;
      logic [31:0] bt, jt;
      logic        v;
      logic [31:0] pc;
      logic        hlt, err;
      logic [31:0] cnt;
      logic        rst, c8;
      logic [7:0]  pc8;
      logic [2:0]  cnt8;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 0, mode = 0, step = 0, stall = 0;
   logic        br = 0, jp = 0, halt = 0;
   logic [31:0] bt = '0, jt = '0;

   logic [31:0] pc, pc_plus, cnt;
   logic        valid, halted, err;
   logic [7:0]  pc8, pc_plus8;
   logic [2:0]  cnt8;
   logic        valid8, halted8, err8;

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   if_pc_unit dut (
      .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_mode(mode),
      .i_step(step), .i_stall(stall), .i_branch_taken(br),
      .i_branch_target(bt), .i_jump(jp), .i_jump_target(jt),
      .i_halt(halt), .o_pc(pc), .o_pc_plus(pc_plus),
      .o_valid(valid), .o_halted(halted), .o_addr_err(err),
      .o_fetch_count(cnt)
   );

   if_pc_unit #(
      .NB_ADDR(8), .RESET_VECTOR(8'h00), .PC_STEP(4), .NB_CNT(3)
   ) dut8 (
      .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_mode(mode),
      .i_step(step), .i_stall(stall), .i_branch_taken(br),
      .i_branch_target(bt[7:0]), .i_jump(jp),
      .i_jump_target(jt[7:0]), .i_halt(halt), .o_pc(pc8),
      .o_pc_plus(pc_plus8), .o_valid(valid8), .o_halted(halted8),
      .o_addr_err(err8), .o_fetch_count(cnt8)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t r(
      input logic e, m, s, st, b, input logic [31:0] btv,
      input logic j, input logic [31:0] jtv, input logic h,
      input logic ev, input logic [31:0] epc,
      input logic eh, ee, input logic [31:0] ec);
      vec_t x;
      x = '0;
      x.en = e; x.mode = m; x.step = s; x.stall = st;
      x.br = b; x.bt = btv; x.jp = j; x.jt = jtv; x.halt = h;
      x.v = ev; x.pc = epc; x.hlt = eh; x.err = ee; x.cnt = ec;
      return x;
   endfunction

   function automatic vec_t w8(input vec_t x, input logic [7:0] p,
                               input logic [2:0] c);
      vec_t y;
      y = x; y.c8 = 1'b1; y.pc8 = p; y.cnt8 = c;
      return y;
   endfunction

   function automatic vec_t rs(input vec_t x);
      vec_t y;
      y = x; y.rst = 1'b1;
      return y;
   endfunction

   // Asynchronous reset in mid-cycle, inputs left as they were.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_pc", 64'(pc), 64'h0);
      chk("rst_halted", 64'(halted), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_cnt", 64'(cnt), 64'h0);
      chk("rst_valid", 64'(valid), 64'(en & !stall));
      #1 rst_n = 1'b1;
   endtask

   task automatic run_row(input int i, input vec_t v);
      vec_t e;
      if (v.rst) do_reset();
      @(negedge clk);
      en = v.en; mode = v.mode; step = v.step; stall = v.stall;
      br = v.br; bt = v.bt; jp = v.jp; jt = v.jt; halt = v.halt;
      #1;
      chk($sformatf("r%0d.valid", i), 64'(valid), 64'(v.v));
      if (v.c8)
         chk($sformatf("r%0d.valid8", i), 64'(valid8), 64'(v.v));
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("r%0d.pc", i), 64'(pc), 64'(e.pc));
      chk($sformatf("r%0d.pc_plus", i), 64'(pc_plus),
          64'(32'(e.pc + 32'd4)));
      chk($sformatf("r%0d.halted", i), 64'(halted), 64'(e.hlt));
      chk($sformatf("r%0d.err", i), 64'(err), 64'(e.err));
      chk($sformatf("r%0d.cnt", i), 64'(cnt), 64'(e.cnt));
      if (e.c8) begin
         chk($sformatf("r%0d.pc8", i), 64'(pc8), 64'(e.pc8));
         chk($sformatf("r%0d.pc_plus8", i), 64'(pc_plus8),
             64'(8'(e.pc8 + 8'd4)));
         chk($sformatf("r%0d.err8", i), 64'(err8), 64'(e.err));
         chk($sformatf("r%0d.halted8", i), 64'(halted8), 64'(e.hlt));
         chk($sformatf("r%0d.cnt8", i), 64'(cnt8), 64'(e.cnt8));
      end
   endtask

   initial begin
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h4,0,0,1));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h8,0,0,2));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'hC,0,0,3));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h10,0,0,4));
      tbl.push_back(r(1,0,0,1, 0,0, 0,0, 0, 0,32'h10,0,0,4));
      tbl.push_back(r(1,0,0,1, 0,0, 1,32'h100, 0, 0,32'h10,0,0,4));
      tbl.push_back(r(1,0,0,1, 0,0, 0,0, 0, 0,32'h10,0,0,4));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h100,0,0,5));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h104,0,0,6));
      tbl.push_back(r(1,0,0,0, 1,32'h40, 1,32'h80, 1,
                      1,32'h40,0,0,7));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h44,0,0,8));
      tbl.push_back(r(1,0,0,0, 0,0, 1,32'h200, 0, 1,32'h200,0,0,9));
      tbl.push_back(r(1,0,0,1, 0,0, 1,32'h300, 0, 0,32'h200,0,0,9));
      tbl.push_back(r(1,0,0,1, 1,32'h500, 1,32'h600, 0,
                      0,32'h200,0,0,9));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h500,0,0,10));
      tbl.push_back(r(1,0,0,1, 1,32'h700, 0,0, 0, 0,32'h500,0,0,10));
      tbl.push_back(r(1,0,0,1, 0,0, 1,32'h800, 0, 0,32'h500,0,0,10));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h800,0,0,11));
      tbl.push_back(r(1,0,0,1, 0,0, 1,32'h900, 0, 0,32'h800,0,0,11));
      tbl.push_back(r(1,0,0,0, 1,32'hA00, 0,0, 0, 1,32'hA00,0,0,12));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'hA04,0,0,13));
      tbl.push_back(r(1,1,0,0, 0,0, 0,0, 0, 1,32'hA08,0,0,14));
      for (int k = 0; k < 4; k++)
         tbl.push_back(r(1,1,0,0, 0,0, 0,0, 0, 0,32'hA08,0,0,14));
      tbl.push_back(r(1,1,1,0, 0,0, 0,0, 0, 1,32'hA0C,0,0,15));
      tbl.push_back(r(1,1,0,0, 0,0, 0,0, 0, 0,32'hA0C,0,0,15));
      tbl.push_back(r(1,1,1,1, 0,0, 0,0, 0, 0,32'hA0C,0,0,15));
      tbl.push_back(r(1,1,0,0, 0,0, 0,0, 0, 0,32'hA0C,0,0,15));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 0,32'hA0C,0,0,15));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'hA10,0,0,16));
      tbl.push_back(r(0,0,0,0, 0,0, 0,0, 0, 0,32'hA10,0,0,16));
      tbl.push_back(r(1,0,0,0, 0,0, 1,32'h1002, 0, 1,32'h1000,0,1,17));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 1,32'h1004,0,1,18));
      tbl.push_back(r(1,0,0,0, 1,32'h20, 0,0, 0, 1,32'h20,0,1,19));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 1, 1,32'h24,1,1,20));
      tbl.push_back(r(1,0,0,0, 1,32'h40, 0,0, 0, 0,32'h24,1,1,20));
      tbl.push_back(r(1,0,0,0, 0,0, 1,32'h50, 0, 0,32'h24,1,1,20));
      tbl.push_back(r(1,0,0,0, 0,0, 0,0, 0, 0,32'h24,1,1,20));
      tbl.push_back(rs(r(1,0,0,1, 0,0, 1,32'h300, 0, 0,32'h0,0,0,0)));
      tbl.push_back(w8(rs(r(1,0,0,0, 0,0, 0,0, 0,
                            1,32'h4,0,0,1)), 8'h04, 3'd1));
      tbl.push_back(w8(r(1,0,0,0, 1,32'hFC, 0,0, 0,
                         1,32'hFC,0,0,2), 8'hFC, 3'd2));
      tbl.push_back(w8(r(1,0,0,0, 0,0, 0,0, 0,
                         1,32'h100,0,0,3), 8'h00, 3'd3));
      tbl.push_back(w8(r(1,0,0,0, 1,32'h13, 0,0, 0,
                         1,32'h10,0,1,4), 8'h10, 3'd4));
      tbl.push_back(w8(r(1,0,0,0, 0,0, 0,0, 0,
                         1,32'h14,0,1,5), 8'h14, 3'd5));
      tbl.push_back(w8(r(1,0,0,0, 0,0, 0,0, 0,
                         1,32'h18,0,1,6), 8'h18, 3'd6));
      tbl.push_back(w8(r(1,0,0,0, 0,0, 0,0, 0,
                         1,32'h1C,0,1,7), 8'h1C, 3'd7));
      tbl.push_back(w8(r(1,0,0,0, 0,0, 0,0, 0,
                         1,32'h20,0,1,8), 8'h20, 3'd7));

      do_reset();
      foreach (tbl[i]) run_row(i, tbl[i]);

      chk("sb_empty", 64'(sb.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
